// File: rtl/cpu_controller.sv
// Instruction register, decoder and Moore sequencer for the 16-bit register/ALU datapath.
// Control strobes are registered from the next state, so they always equal the decode of the current state.
module cpu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] in,
  input  logic        s,
  output logic        w,
  output logic        illegal,
  output logic [1:0]  vsel,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  localparam int unsigned IR_W  = 16;
  localparam int unsigned REG_W = 3;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG
  } state_t;

  typedef struct packed {
    logic             w;
    logic             illegal;
    logic [1:0]       vsel;
    logic [REG_W-1:0] writenum;
    logic [REG_W-1:0] readnum;
    logic             write;
    logic             loada;
    logic             loadb;
    logic             loadc;
    logic             loads;
    logic             asel;
    logic             bsel;
    logic [1:0]       alu_op;
  } ctrl_t;

  state_t          state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  ctrl_t           ctrl_q, ctrl_d;

  logic [2:0]       opcode;
  logic [1:0]       op;
  logic [REG_W-1:0] rn, rd, rm;
  logic             is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, is_legal;

  // IR only changes in WAIT, so ir_d equals ir_q for the whole instruction
  always_comb begin
    ir_d = ir_q;
    if (load && (state_q == S_WAIT)) ir_d = in;
  end

  assign opcode = ir_d[15:13];
  assign op     = ir_d[12:11];
  assign rn     = ir_d[10:8];
  assign rd     = ir_d[7:5];
  assign rm     = ir_d[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign is_legal   = is_mov_imm || is_mov_reg || is_alu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_WAIT;
      ir_q     <= '0;
      ctrl_q   <= '0;
      ctrl_q.w <= 1'b1;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Next state, then the Moore outputs belonging to that next state
  always_comb begin
    state_d = state_q;
    ctrl_d  = '0;

    case (state_q)
      S_WAIT:      if (s) state_d = S_DECODE;
      S_DECODE: begin
        if (is_mov_imm)               state_d = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn) state_d = S_GET_B;
        else if (is_alu)              state_d = S_GET_A;
        else                          state_d = S_WAIT;
      end
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_EXEC;
      S_EXEC:      state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_IMM: state_d = S_WAIT;
      S_WRITE_REG: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase

    case (state_d)
      S_WAIT:   ctrl_d.w = 1'b1;
      S_DECODE: ctrl_d.illegal = !is_legal;
      S_WRITE_IMM: begin
        ctrl_d.writenum = rn;
        ctrl_d.vsel     = 2'b01;
        ctrl_d.write    = 1'b1;
      end
      S_GET_A: begin
        ctrl_d.readnum = rn;
        ctrl_d.loada   = 1'b1;
      end
      S_GET_B: begin
        ctrl_d.readnum = rm;
        ctrl_d.loadb   = 1'b1;
      end
      S_EXEC: begin
        ctrl_d.asel   = is_mov_reg || is_mvn;
        ctrl_d.bsel   = 1'b0;
        ctrl_d.alu_op = is_mov_reg ? 2'b00 : op;
        ctrl_d.loads  = is_cmp;
        ctrl_d.loadc  = !is_cmp;
      end
      S_WRITE_REG: begin
        ctrl_d.writenum = rd;
        ctrl_d.vsel     = 2'b11;
        ctrl_d.write    = 1'b1;
      end
      default: ;
    endcase
  end

  assign w        = ctrl_q.w;
  assign illegal  = ctrl_q.illegal;
  assign vsel     = ctrl_q.vsel;
  assign writenum = ctrl_q.writenum;
  assign readnum  = ctrl_q.readnum;
  assign write    = ctrl_q.write;
  assign loada    = ctrl_q.loada;
  assign loadb    = ctrl_q.loadb;
  assign loadc    = ctrl_q.loadc;
  assign loads    = ctrl_q.loads;
  assign asel     = ctrl_q.asel;
  assign bsel     = ctrl_q.bsel;
  assign ALUop    = ctrl_q.alu_op;

  assign shift  = ir_q[4:3];
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

endmodule
